// File: rtl/spi_adc_pkg.sv
// Shared definitions for the SPI sample responder (ADC side of the 16-bit
// inverted-clock sample frame).
package spi_adc_pkg;

  // Default frame geometry: 16 SCLK periods carrying a 12-bit sample.
  localparam int unsigned FRAME_BITS_DEF  = 16;
  localparam int unsigned SAMPLE_BITS_DEF = 12;
  localparam int unsigned LEAD_ZEROS      = FRAME_BITS_DEF - SAMPLE_BITS_DEF;

  // Responder frame state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for one asynchronous input with edge detection.
// All flops reset to 1 so an idle-high line (cs_n, CPOL=1 sclk) never shows
// a spurious edge coming out of reset.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_a_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the pin through the synchroniser and remember the last synchronised level.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_sync <= {SYNC_STAGES{1'b1}};
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_sample_responder.sv
// SPI slave playing the ADC side of the sample frame: takes 12-bit samples
// over valid/ready and shifts them out MSB first behind leading zeros.
// miso changes on synchronised SCLK falling edges; the first bit is put on
// the line as soon as the frame select is seen.
module spi_sample_responder
  import spi_adc_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
  parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_a_n,
  input  logic [SAMPLE_BITS-1:0] sample_i,
  input  logic                   sample_valid_i,
  output logic                   sample_ready_o,
  input  logic                   sclk_i,
  input  logic                   cs_n_i,
  output logic                   miso_o,
  output logic                   miso_oe_o,
  output logic                   frame_done_o,
  output logic                   frame_abort_o,
  output logic                   underrun_o
);

  localparam int unsigned LEAD_Z   = FRAME_BITS - SAMPLE_BITS;
  localparam int unsigned CNT_W    = $clog2(FRAME_BITS);
  localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0]    LAST_BIT    = CNT_W'(FRAME_BITS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

  // Synchronised pin views.
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_unused_sclk;

  // Registered state.
  state_t                  r_state;
  logic [FRAME_BITS-1:0]   r_shreg;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [SAMPLE_BITS-1:0]  r_hold;
  logic                    r_hold_full;
  logic [SAMPLE_BITS-1:0]  r_last;
  logic                    r_miso;
  logic                    r_oe;
  logic                    r_done;
  logic                    r_abort;
  logic                    r_underrun;
  logic [SETTLE_W-1:0]     r_settle_cnt;
  logic                    r_armed;

  // Next-state values.
  state_t                  w_state_nxt;
  logic [FRAME_BITS-1:0]   w_shreg_nxt;
  logic [CNT_W-1:0]        w_bit_cnt_nxt;
  logic [SAMPLE_BITS-1:0]  w_hold_nxt;
  logic                    w_hold_full_nxt;
  logic [SAMPLE_BITS-1:0]  w_last_nxt;
  logic                    w_miso_nxt;
  logic                    w_done_nxt;
  logic                    w_abort_nxt;
  logic                    w_underrun_nxt;

  logic                    w_xfer;
  logic                    w_cs_start;
  logic [SAMPLE_BITS-1:0]  w_payload;
  logic [FRAME_BITS-1:0]   w_frame_load;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk     (clk),
    .rst_a_n (rst_a_n),
    .i_async (cs_n_i),
    .o_level (w_cs_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .rst_a_n (rst_a_n),
    .i_async (sclk_i),
    .o_level (w_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // Only the SCLK falling edge drives the shifter; the other views are unused.
  assign w_unused_sclk = w_sclk_level ^ w_sclk_rise;

  assign w_xfer       = sample_valid_i & ~r_hold_full;
  assign w_cs_start   = w_cs_fall & r_armed;
  assign w_payload    = r_hold_full ? r_hold : r_last;
  assign w_frame_load = {{LEAD_Z{1'b0}}, w_payload};

  // Arm frame start only once the synchroniser has flushed its reset value and
  // cs_n has been seen high, so a cs_n held low through reset release is no start.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_settle_cnt <= {SETTLE_W{1'b0}};
      r_armed      <= 1'b0;
    end else begin
      if (r_settle_cnt != SETTLE_DONE) begin
        r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
      end else begin
        r_settle_cnt <= r_settle_cnt;
      end
      if ((r_settle_cnt == SETTLE_DONE) && w_cs_level) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  // Next-state, shifter, holding register and output decode for the frame FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_last_nxt      = r_last;
    w_miso_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_abort_nxt     = 1'b0;
    w_underrun_nxt  = 1'b0;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;

    if (w_xfer) begin
      w_hold_nxt      = sample_i;
      w_hold_full_nxt = 1'b1;
    end else begin
      w_hold_nxt      = r_hold;
      w_hold_full_nxt = r_hold_full;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_cs_start) begin
          w_shreg_nxt     = w_frame_load;
          w_last_nxt      = w_payload;
          w_underrun_nxt  = ~r_hold_full;
          // A sample accepted in this same cycle is kept for the next frame.
          w_hold_full_nxt = w_xfer;
          w_miso_nxt      = w_frame_load[FRAME_BITS-1];
          w_bit_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt     = ST_SHIFT;
        end else begin
          w_miso_nxt      = 1'b0;
        end
      end
      ST_SHIFT: begin
        // A closing frame select beats a coincident SCLK edge.
        if (w_cs_rise) begin
          w_abort_nxt = 1'b1;
          w_miso_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_fall) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_done_nxt  = 1'b1;
            w_miso_nxt  = 1'b0;
            w_state_nxt = ST_TAIL;
          end else begin
            w_shreg_nxt   = {r_shreg[FRAME_BITS-2:0], 1'b0};
            w_miso_nxt    = r_shreg[FRAME_BITS-2];
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end else begin
          w_miso_nxt = r_miso;
        end
      end
      ST_TAIL: begin
        // Extra clocks after the frame only ever see zeros.
        w_miso_nxt = 1'b0;
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_TAIL;
        end
      end
      default: begin
        w_miso_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register FSM state, datapath and all outputs.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_state     <= ST_IDLE;
      r_shreg     <= {FRAME_BITS{1'b0}};
      r_bit_cnt   <= {CNT_W{1'b0}};
      r_hold      <= {SAMPLE_BITS{1'b0}};
      r_hold_full <= 1'b0;
      r_last      <= {SAMPLE_BITS{1'b0}};
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_last      <= w_last_nxt;
      r_miso      <= w_miso_nxt;
      r_oe        <= (w_state_nxt != ST_IDLE);
      r_done      <= w_done_nxt;
      r_abort     <= w_abort_nxt;
      r_underrun  <= w_underrun_nxt;
    end
  end

  assign sample_ready_o = ~r_hold_full;
  assign miso_o         = r_miso;
  assign miso_oe_o      = r_oe;
  assign frame_done_o   = r_done;
  assign frame_abort_o  = r_abort;
  assign underrun_o     = r_underrun;

endmodule

// File: tb/tb_spi_sample_responder.sv
// Bench for spi_sample_responder: acts as the SPI master (clk:SCLK = 8) and
// local sample source. Expected miso bits are queued when a frame is set up
// and popped as each bit is sampled at the end of the SCLK high phase.
module tb_spi_sample_responder;

  logic        clk = 1'b0;
  logic        rst_a_n = 1'b0;
  logic [11:0] sample_i = 12'h000;
  logic        sample_valid_i = 1'b0;
  logic        sample_ready_o;
  logic        sclk_i = 1'b1;
  logic        cs_n_i = 1'b1;
  logic        miso_o;
  logic        miso_oe_o;
  logic        frame_done_o;
  logic        frame_abort_o;
  logic        underrun_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_abort = 0;
  int n_under = 0;
  bit exp_q[$];

  spi_sample_responder dut (
    .clk            (clk),
    .rst_a_n        (rst_a_n),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .sclk_i         (sclk_i),
    .cs_n_i         (cs_n_i),
    .miso_o         (miso_o),
    .miso_oe_o      (miso_oe_o),
    .frame_done_o   (frame_done_o),
    .frame_abort_o  (frame_abort_o),
    .underrun_o     (underrun_o)
  );

  always #5 clk = ~clk;

  // Count pulse-cycles of each event output.
  always @(negedge clk) begin
    if (frame_done_o)  n_done++;
    if (frame_abort_o) n_abort++;
    if (underrun_o)    n_under++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue the bits the master should see for nclk SCLK periods.
  task automatic push_frame(input logic [15:0] frame, input int nclk);
    for (int k = 0; k < nclk; k++) begin
      if (k < 16) exp_q.push_back(frame[15-k]);
      else        exp_q.push_back(1'b0);
    end
  endtask

  task automatic load_sample(input logic [11:0] v);
    int n;
    n = 0;
    @(negedge clk);
    sample_i = v;
    sample_valid_i = 1'b1;
    while (!sample_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (sample_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load_ready: ready=%0b after %0d cycles, required 1", sample_ready_o, n);
    end
    @(negedge clk);
    sample_valid_i = 1'b0;
    n_tests++;
    if (sample_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_hold_full: ready=%0b after transfer, required 0", sample_ready_o);
    end
  endtask

  // Run nclk SCLK periods, checking each bit against the scoreboard before the fall.
  task automatic clock_bits(input int nclk, input string tag);
    for (int k = 0; k < nclk; k++) begin
      bit exp_b;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s bit %0d: scoreboard empty, miso=%0b", tag, k, miso_o);
      end else begin
        exp_b = exp_q.pop_front();
        if (miso_o !== exp_b || miso_oe_o !== 1'b1) begin
          n_fail++;
          $display("FAIL %s bit %0d: miso=%0b oe=%0b, required miso=%0b oe=1",
                   tag, k, miso_o, miso_oe_o, exp_b);
        end
      end
      sclk_i = 1'b0;
      wait_clks(4);
      sclk_i = 1'b1;
      wait_clks(4);
    end
  endtask

  task automatic check_frame_end(input string tag, input int d0, input int a0, input int u0,
                                 input int exp_done, input int exp_abort, input int exp_under);
    n_tests++;
    if ((n_done - d0) != exp_done || (n_abort - a0) != exp_abort || (n_under - u0) != exp_under) begin
      n_fail++;
      $display("FAIL %s pulses: done=%0d abort=%0d underrun=%0d, required %0d %0d %0d",
               tag, n_done - d0, n_abort - a0, n_under - u0, exp_done, exp_abort, exp_under);
    end
    n_tests++;
    if (miso_oe_o !== 1'b0 || miso_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s idle: oe=%0b miso=%0b left_in_queue=%0d, required 0 0 0",
               tag, miso_oe_o, miso_o, exp_q.size());
    end
  endtask

  task automatic run_frame(input logic [15:0] frame, input int nclk, input int exp_under,
                           input string tag);
    int d0, a0, u0;
    d0 = n_done; a0 = n_abort; u0 = n_under;
    push_frame(frame, nclk);
    @(negedge clk);
    cs_n_i = 1'b0;
    wait_clks(6);
    clock_bits(nclk, tag);
    wait_clks(4);
    cs_n_i = 1'b1;
    wait_clks(8);
    check_frame_end(tag, d0, a0, u0, 1, 0, exp_under);
  endtask

  task automatic test_reset();
    wait_clks(2);
    n_tests++;
    if (miso_o !== 1'b0 || miso_oe_o !== 1'b0 || sample_ready_o !== 1'b1 ||
        frame_done_o !== 1'b0 || frame_abort_o !== 1'b0 || underrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: miso=%0b oe=%0b ready=%0b done=%0b abort=%0b under=%0b, required 0 0 1 0 0 0",
               miso_o, miso_oe_o, sample_ready_o, frame_done_o, frame_abort_o, underrun_o);
    end
    rst_a_n = 1'b1;
    wait_clks(10);
    n_tests++;
    if (miso_oe_o !== 1'b0 || sample_ready_o !== 1'b1 || n_done != 0 || n_abort != 0 || n_under != 0) begin
      n_fail++;
      $display("FAIL reset_release: oe=%0b ready=%0b pulses=%0d/%0d/%0d, required 0 1 0/0/0",
               miso_oe_o, sample_ready_o, n_done, n_abort, n_under);
    end
  endtask

  task automatic test_underrun();
    run_frame(16'h0000, 16, 1, "underrun_empty");
    load_sample(12'h123);
    run_frame(16'h0123, 16, 0, "underrun_loaded");
    run_frame(16'h0123, 16, 1, "underrun_repeat");
  endtask

  task automatic test_single_frame();
    load_sample(12'hA5C);
    run_frame(16'b0000_1010_0101_1100, 16, 0, "single_frame");
  endtask

  task automatic test_abort();
    int d0, a0, u0;
    load_sample(12'h7E1);
    d0 = n_done; a0 = n_abort; u0 = n_under;
    push_frame(16'h07E1, 7);
    @(negedge clk);
    cs_n_i = 1'b0;
    wait_clks(6);
    clock_bits(7, "abort");
    wait_clks(4);
    cs_n_i = 1'b1;
    wait_clks(3);
    n_tests++;
    if (miso_oe_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_oe: oe=%0b 3 cycles after cs_n rise, required 0", miso_oe_o);
    end
    wait_clks(5);
    check_frame_end("abort", d0, a0, u0, 0, 1, 0);
    load_sample(12'h9B6);
    run_frame(16'h09B6, 16, 0, "after_abort");
  endtask

  task automatic test_overlong();
    load_sample(12'hFFF);
    run_frame(16'h0FFF, 20, 0, "overlong");
  endtask

  task automatic test_back_to_back_load();
    int d0, a0, u0;
    load_sample(12'h555);
    run_frame(16'h0555, 16, 0, "simul_prep");
    d0 = n_done; a0 = n_abort; u0 = n_under;
    push_frame(16'h0555, 16);
    @(negedge clk);
    cs_n_i = 1'b0;
    wait_clks(2);
    // The next rising clk edge is the cs_fall detect cycle.
    n_tests++;
    if (sample_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_ready: ready=%0b before detect, required 1", sample_ready_o);
    end
    sample_i = 12'h0F0;
    sample_valid_i = 1'b1;
    wait_clks(1);
    sample_valid_i = 1'b0;
    n_tests++;
    if (sample_ready_o !== 1'b0 || miso_oe_o !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_start: ready=%0b oe=%0b, required 0 1", sample_ready_o, miso_oe_o);
    end
    wait_clks(3);
    clock_bits(16, "simul_frame");
    wait_clks(4);
    cs_n_i = 1'b1;
    wait_clks(8);
    check_frame_end("simul_frame", d0, a0, u0, 1, 0, 1);
    run_frame(16'h00F0, 16, 0, "simul_next");
  endtask

  task automatic test_reset_mid_frame();
    int d0, a0, u0, oe_seen;
    load_sample(12'h3AB);
    push_frame(16'h03AB, 16);
    @(negedge clk);
    cs_n_i = 1'b0;
    wait_clks(6);
    clock_bits(9, "rst_mid");
    rst_a_n = 1'b0;
    #1;
    n_tests++;
    if (miso_o !== 1'b0 || miso_oe_o !== 1'b0 || sample_ready_o !== 1'b1 ||
        frame_done_o !== 1'b0 || frame_abort_o !== 1'b0 || underrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_values: miso=%0b oe=%0b ready=%0b done=%0b abort=%0b under=%0b, required 0 0 1 0 0 0",
               miso_o, miso_oe_o, sample_ready_o, frame_done_o, frame_abort_o, underrun_o);
    end
    exp_q.delete();
    wait_clks(3);
    rst_a_n = 1'b1;
    d0 = n_done; a0 = n_abort; u0 = n_under;
    oe_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (miso_oe_o) oe_seen++;
    end
    n_tests++;
    if (oe_seen != 0 || (n_under - u0) != 0 || (n_done - d0) != 0 || (n_abort - a0) != 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_start: oe_cycles=%0d pulses=%0d/%0d/%0d, required 0 0/0/0",
               oe_seen, n_done - d0, n_abort - a0, n_under - u0);
    end
    cs_n_i = 1'b1;
    wait_clks(10);
    load_sample(12'h2C4);
    run_frame(16'h02C4, 16, 0, "rst_mid_next");
  endtask

  initial begin
    test_reset();
    test_underrun();
    test_single_frame();
    test_abort();
    test_overlong();
    test_back_to_back_load();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
